// File: rtl/out_buf_rd_drain_pkg.sv
// out_buf_rd_drain_pkg: drain FSM states, FIFO sizing helper and default PE column counts
`ifndef HW_LUT_PE_COLS
`define HW_LUT_PE_COLS 16
`endif
`ifndef HW_DSP_PE_COLS
`define HW_DSP_PE_COLS 8
`endif
package out_buf_rd_drain_pkg;
  typedef enum logic [2:0] {IDLE, BS, BP, DRAIN, ZERO} rd_state_e;
  function automatic int ob_fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction
endpackage

// File: rtl/out_buf_rd_drain_if.sv
// out_buf_rd_drain_if: valid/ready output stream toward the output DMA
interface out_buf_rd_drain_if #(parameter int DATA_W = 64);
  logic [DATA_W-1:0] m_data;
  logic m_valid;
  logic m_ready;
  logic m_last;
  modport master (output m_data, m_valid, m_last, input m_ready);
  modport slave (input m_data, m_valid, m_last, output m_ready);
endinterface

// File: rtl/ob_rd_fifo.sv
// ob_rd_fifo: small synchronous FIFO with occupancy count; caller never pushes when full
module ob_rd_fifo #(
  parameter int W = 65,
  parameter int DEPTH = 3,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] cnt
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  assign dout = mem[rd_ptr];
  assign empty = cnt == '0;
endmodule

// File: rtl/out_buf_rd_drain.sv
// out_buf_rd_drain: drains BS then BP output buffers per tile onto a valid/ready stream.
// Defining HW_OB_RD_STALL_CNT_EN adds the rd_stall_cnt back-pressure cycle counter.
module out_buf_rd_drain
  import out_buf_rd_drain_pkg::*;
#(
  parameter int BS_COLS = `HW_LUT_PE_COLS,
  parameter int BP_COLS = `HW_DSP_PE_COLS,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [15:0]                bs_rd_times,
  input  logic [15:0]                bp_rd_times,
  input  logic                       rd_tile_start,
  output logic                       bs_out_buf_rd_vld,
  output logic [2:0]                 bs_out_buf_rd_en,
  output logic [BS_COLS*ADDR_W-1:0]  bs_out_buf_rd_addr,
  input  logic [DATA_W-1:0]          bs_out_buf_rd_data,
  output logic                       bp_out_buf_rd_vld,
  output logic [2:0]                 bp_out_buf_rd_en,
  output logic [BP_COLS*ADDR_W-1:0]  bp_out_buf_rd_addr,
  input  logic [DATA_W-1:0]          bp_out_buf_rd_data,
  out_buf_rd_drain_if.master         m,
  output logic                       rd_busy,
  output logic                       rd_tile_end
`ifdef HW_OB_RD_STALL_CNT_EN
  , output logic [31:0]              rd_stall_cnt
`endif
);
  localparam int DEPTH = ob_fifo_depth(RD_LAT);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BS_BANKS = BS_COLS / 8;
  localparam int BP_BANKS = BP_COLS / 4;
  rd_state_e state, state_d;
  logic [15:0] bs_n, bp_n, idx;
  logic [RD_LAT-1:0] sr_vld, sr_src, sr_last;
  logic bs_end, bp_end, credit, issue, last_in, pop, end_q, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [DATA_W:0] fifo_dout;
  always_comb begin
    bs_end = idx == bs_n - 16'd1;
    bp_end = idx == bp_n - 16'd1;
    pop = m.m_valid && m.m_ready;
    // reads in flight plus queued beats must never exceed the FIFO depth
    credit = 8'($countones(sr_vld)) + 8'(fifo_cnt) - 8'(pop) < 8'(DEPTH);
    issue = (state == BS || state == BP) && credit;
    last_in = (state == BP) ? bp_end : (bs_end && bp_n == '0);
    state_d = state;
    case (state)
      IDLE:    if (rd_tile_start) state_d = (bs_rd_times != '0) ? BS : (bp_rd_times != '0) ? BP : ZERO;
      BS:      if (issue && bs_end) state_d = (bp_n != '0) ? BP : DRAIN;
      BP:      if (issue && bp_end) state_d = DRAIN;
      DRAIN:   if (sr_vld == '0 && fifo_empty) state_d = IDLE;
      ZERO:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      bs_n <= '0;
      bp_n <= '0;
      idx <= '0;
      sr_vld <= '0;
      sr_src <= '0;
      sr_last <= '0;
      end_q <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && rd_tile_start) begin
        bs_n <= bs_rd_times;
        bp_n <= bp_rd_times;
      end
      if (issue) idx <= ((state == BS) ? bs_end : bp_end) ? '0 : idx + 16'd1;
      sr_vld <= RD_LAT'({sr_vld, issue});
      sr_src <= RD_LAT'({sr_src, state == BP});
      sr_last <= RD_LAT'({sr_last, issue && last_in});
      end_q <= pop && m.m_last;
    end
  end
  assign bs_out_buf_rd_vld = issue && state == BS;
  assign bp_out_buf_rd_vld = issue && state == BP;
  assign bs_out_buf_rd_en = bs_out_buf_rd_vld ? 3'(idx % BS_BANKS) : '0;
  assign bp_out_buf_rd_en = bp_out_buf_rd_vld ? 3'(idx % BP_BANKS) : '0;
  assign bs_out_buf_rd_addr = bs_out_buf_rd_vld ? {BS_COLS{ADDR_W'(idx)}} : '0;
  assign bp_out_buf_rd_addr = bp_out_buf_rd_vld ? {BP_COLS{ADDR_W'(idx)}} : '0;
  ob_rd_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (sr_vld[RD_LAT-1]),
    .din   ({sr_last[RD_LAT-1], sr_src[RD_LAT-1] ? bp_out_buf_rd_data : bs_out_buf_rd_data}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .cnt   (fifo_cnt)
  );
  assign m.m_valid = !fifo_empty;
  assign m.m_data = m.m_valid ? fifo_dout[DATA_W-1:0] : '0;
  assign m.m_last = m.m_valid && fifo_dout[DATA_W];
  assign rd_busy = state != IDLE;
  assign rd_tile_end = end_q || state == ZERO;
`ifdef HW_OB_RD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || (state == IDLE && rd_tile_start)) rd_stall_cnt <= '0;
    else if (m.m_valid && !m.m_ready && !(&rd_stall_cnt)) rd_stall_cnt <= rd_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_out_buf_rd_drain.sv
// tb_out_buf_rd_drain: directed scoreboard bench for out_buf_rd_drain
module tb_out_buf_rd_drain;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] bs_rd_times, bp_rd_times;
  logic rd_tile_start;
  logic bs_vld, bp_vld;
  logic [2:0] bs_en, bp_en;
  logic [255:0] bs_addr;
  logic [127:0] bp_addr;
  logic [63:0] bs_data, bp_data;
  logic rd_busy, rd_tile_end;
`ifdef HW_OB_RD_STALL_CNT_EN
  logic [31:0] rd_stall_cnt;
`endif
  out_buf_rd_drain_if #(.DATA_W(64)) m_if ();
  out_buf_rd_drain #(.BS_COLS(16), .BP_COLS(8), .ADDR_W(16), .DATA_W(64), .RD_LAT(1)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bs_rd_times        (bs_rd_times),
    .bp_rd_times        (bp_rd_times),
    .rd_tile_start      (rd_tile_start),
    .bs_out_buf_rd_vld  (bs_vld),
    .bs_out_buf_rd_en   (bs_en),
    .bs_out_buf_rd_addr (bs_addr),
    .bs_out_buf_rd_data (bs_data),
    .bp_out_buf_rd_vld  (bp_vld),
    .bp_out_buf_rd_en   (bp_en),
    .bp_out_buf_rd_addr (bp_addr),
    .bp_out_buf_rd_data (bp_data),
    .m                  (m_if),
    .rd_busy            (rd_busy),
`ifdef HW_OB_RD_STALL_CNT_EN
    .rd_stall_cnt       (rd_stall_cnt),
`endif
    .rd_tile_end        (rd_tile_end)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int bs_strb, bp_strb, exp_beats, n_end = 0, end_base, stall_model, rc = 0;
  bit toggle = 0, zero_mode = 0, saw_pause, last_hs_prev, stall_prev;
  logic [64:0] hold_val;
  logic [64:0] sb [$];
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // buffer model: one-cycle read latency, garbage when not strobed
  always @(posedge clk) begin
    bs_data <= bs_vld ? {8'hB5, 40'h0, bs_addr[15:0]} : {$urandom, $urandom};
    bp_data <= bp_vld ? {8'hB9, 40'h0, bp_addr[15:0]} : {$urandom, $urandom};
  end
  always @(posedge clk) begin
    #1;
    rc++;
    m_if.m_ready = toggle ? (rc % 3 == 0) : 1'b1;
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      last_hs_prev = 0;
      stall_prev = 0;
    end else begin
      if (bs_vld) begin
        check("bs_bank", 256'(bs_en), 256'(bs_strb % 2));
        check("bs_addr", bs_addr, {16{16'(bs_strb)}});
        bs_strb++;
      end
      if (bp_vld) begin
        check("bp_bank", 256'(bp_en), 256'(bp_strb % 2));
        check("bp_addr", 256'(bp_addr), 256'({8{16'(bp_strb)}}));
        bp_strb++;
      end
      if (rd_busy && !bs_vld && !bp_vld && bs_strb + bp_strb > 0 && bs_strb + bp_strb < exp_beats) saw_pause = 1;
      if (stall_prev) check("hold", 256'({m_if.m_last, m_if.m_data}), 256'(hold_val));
      if (!zero_mode) check("tile_end", 256'(rd_tile_end), 256'(last_hs_prev));
      if (rd_tile_end) n_end++;
      if (m_if.m_valid && m_if.m_ready) begin
        if (sb.size() == 0) check("extra_beat", 256'(sb.size()), 256'(1));
        else check("beat", 256'({m_if.m_last, m_if.m_data}), 256'(sb.pop_front()));
      end
      if (m_if.m_valid && !m_if.m_ready) stall_model++;
      stall_prev = m_if.m_valid && !m_if.m_ready;
      hold_val = {m_if.m_last, m_if.m_data};
      last_hs_prev = m_if.m_valid && m_if.m_ready && m_if.m_last;
    end
  end
  task automatic start_tile(input int bs, input int bp);
    for (int i = 0; i < bs; i++) sb.push_back({i == bs - 1 && bp == 0, 8'hB5, 40'h0, 16'(i)});
    for (int i = 0; i < bp; i++) sb.push_back({i == bp - 1, 8'hB9, 40'h0, 16'(i)});
    @(posedge clk);
    #1;
    bs_strb = 0;
    bp_strb = 0;
    exp_beats = bs + bp;
    saw_pause = 0;
    end_base = n_end;
    stall_model = 0;
    bs_rd_times = 16'(bs);
    bp_rd_times = 16'(bp);
    rd_tile_start = 1'b1;
    @(posedge clk);
    #1;
    rd_tile_start = 1'b0;
    bs_rd_times = 16'($urandom_range(1, 9));
    bp_rd_times = 16'($urandom_range(1, 9));
  endtask
  task automatic wait_end(input string tag, input int bs, input int bp);
    int t = 0;
    while (n_end == end_base && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_end_cnt"}, 256'(n_end - end_base), 256'(1));
    check({tag, "_sb_left"}, 256'(sb.size()), 256'(0));
    check({tag, "_bs_strb"}, 256'(bs_strb), 256'(bs));
    check({tag, "_bp_strb"}, 256'(bp_strb), 256'(bp));
  endtask
  initial begin
    rst_n = 1'b0;
    rd_tile_start = 1'b0;
    bs_rd_times = '0;
    bp_rd_times = '0;
    m_if.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 256'(rd_busy), 256'(0));
    check("rst_valid", 256'(m_if.m_valid), 256'(0));
    check("rst_data", 256'({m_if.m_last, m_if.m_data}), 256'(0));
    check("rst_strobe", 256'({bs_vld, bp_vld, bs_en, bp_en}), 256'(0));
    check("rst_addr", bs_addr | 256'(bp_addr), 256'(0));
    check("rst_end", 256'(rd_tile_end), 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // 4 BS + 3 BP beats, full throughput
    start_tile(4, 3);
    @(negedge clk);
    check("first_strobe", 256'(bs_vld), 256'(1));
    @(negedge clk);
    check("early_valid", 256'(m_if.m_valid), 256'(0));
    @(negedge clk);
    check("first_valid", 256'(m_if.m_valid), 256'(1));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_bubble", 256'(m_if.m_valid), 256'(1));
    end
    @(negedge clk);
    check("end_after_last", 256'(rd_tile_end), 256'(1));
    wait_end("t43", 4, 3);
    // empty tile
    zero_mode = 1;
    start_tile(0, 0);
    @(negedge clk);
    check("zero_busy1", 256'({rd_busy, rd_tile_end}), 256'(2'b11));
    @(negedge clk);
    check("zero_busy2", 256'({rd_busy, rd_tile_end}), 256'(2'b00));
    check("zero_strb", 256'(bs_strb + bp_strb), 256'(0));
    zero_mode = 0;
    repeat (2) @(negedge clk);
    // BS only
    start_tile(5, 0);
    wait_end("t50", 5, 0);
    // back-pressure
    toggle = 1;
    start_tile(8, 8);
    wait_end("t88", 8, 8);
    check("credit_pause", 256'(saw_pause), 256'(1));
`ifdef HW_OB_RD_STALL_CNT_EN
    check("stall_cnt", 256'(rd_stall_cnt), 256'(stall_model));
`endif
    toggle = 0;
    repeat (2) @(negedge clk);
    // reset in the middle of the BP phase
    start_tile(8, 8);
    for (int t = 0; t < 100 && bp_strb < 2; t++) @(negedge clk);
    check("reached_bp", 256'(bp_strb >= 2), 256'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_ctl", 256'({rd_busy, rd_tile_end, m_if.m_valid, m_if.m_last, bs_vld, bp_vld, bs_en, bp_en}), 256'(0));
    check("midrst_bus", bs_addr | 256'(bp_addr) | 256'(m_if.m_data), 256'(0));
    start_tile(2, 2);
    wait_end("t22", 2, 2);
    // restart pulse while busy must be ignored
    start_tile(3, 2);
    @(posedge clk);
    #1;
    bs_rd_times = 16'd1;
    bp_rd_times = 16'd1;
    rd_tile_start = 1'b1;
    @(posedge clk);
    #1;
    rd_tile_start = 1'b0;
    wait_end("t32", 3, 2);
    repeat (10) @(negedge clk);
    check("single_end", 256'(n_end - end_base), 256'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
